// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the button conditioner: channel FSM encoding,
// default timing constants and a counter-width helper.
package tamagotchi_pkg;

    localparam int DEF_N_BTN      = 5;      // Sleep, Awake, Feed, Play, Test
    localparam int DEF_TICK_DIV   = 50000;  // 1 ms tick at 50 MHz
    localparam int DEF_DEB_TICKS  = 20;     // stable ticks to accept a change
    localparam int DEF_LONG_TICKS = 5000;   // held ticks before a long press

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_PRESSED     = 3'd2,
        ST_LONG        = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } btn_state_e;

    // Bits needed to hold a counter that saturates at thr.
    function automatic int cnt_width(input int thr);
        return (thr < 1) ? 1 : $clog2(thr + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw active-low inputs plus the conditioned level and
// event pulses, one bit per channel.
interface button_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [N_BTN-1:0] release_pulse;

    modport master (
        output btn_n,
        input  level, press_pulse, long_pulse, release_pulse
    );

    modport slave (
        input  btn_n,
        output level, press_pulse, long_pulse, release_pulse
    );
endinterface

// File: rtl/btn_channel.sv
// One button channel: synchronizer, debounce/long-press FSM and
// registered one-clock event pulses.
module btn_channel
    import tamagotchi_pkg::*;
#(
    parameter int DEB_TICKS  = DEF_DEB_TICKS,
    parameter int LONG_TICKS = DEF_LONG_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_n,
    output logic level,
    output logic press_pulse,
    output logic long_pulse,
    output logic release_pulse
);
    localparam int DEB_W  = cnt_width(DEB_TICKS);
    localparam int HOLD_W = cnt_width(LONG_TICKS);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

    logic [1:0]        sync_q;
    logic              s;
    btn_state_e        state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d, deb_inc;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic              from_long_q, from_long_d;
    logic              press_q, press_d;
    logic              long_q, long_d;
    logic              rel_q, rel_d;

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], btn_n};
    end

    assign s = ~sync_q[1];

    // Saturating increments so the counters can never wrap.
    always_comb begin
        deb_inc  = (deb_q == DEB_MAX)   ? deb_q  : deb_q + DEB_W'(1);
        hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
    end

    // Next-state and pulse decode; a release glitch returns to the origin state.
    always_comb begin
        state_d     = state_q;
        deb_d       = deb_q;
        hold_d      = hold_q;
        from_long_d = from_long_q;
        press_d     = 1'b0;
        long_d      = 1'b0;
        rel_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_DEB_PRESS;
                    deb_d   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    deb_d = deb_inc;
                    if (deb_inc == DEB_MAX) begin
                        state_d = ST_PRESSED;
                        hold_d  = '0;
                        press_d = 1'b1;
                    end
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d     = ST_DEB_RELEASE;
                    deb_d       = '0;
                    from_long_d = 1'b0;
                end else if (tick) begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_MAX) begin
                        state_d = ST_LONG;
                        long_d  = 1'b1;
                    end
                end
            end
            ST_LONG: begin
                if (!s) begin
                    state_d     = ST_DEB_RELEASE;
                    deb_d       = '0;
                    from_long_d = 1'b1;
                end
            end
            ST_DEB_RELEASE: begin
                if (s) begin
                    state_d = from_long_q ? ST_LONG : ST_PRESSED;
                end else if (tick) begin
                    deb_d = deb_inc;
                    if (deb_inc == DEB_MAX) begin
                        state_d = ST_IDLE;
                        rel_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, counters and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            deb_q       <= '0;
            hold_q      <= '0;
            from_long_q <= 1'b0;
            press_q     <= 1'b0;
            long_q      <= 1'b0;
            rel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            from_long_q <= from_long_d;
            press_q     <= press_d;
            long_q      <= long_d;
            rel_q       <= rel_d;
        end
    end

    // The button counts as pressed from acceptance until release is accepted.
    assign level = (state_q == ST_PRESSED) || (state_q == ST_LONG) ||
                   (state_q == ST_DEB_RELEASE);
    assign press_pulse   = press_q;
    assign long_pulse    = long_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner top: shared tick prescaler feeding N_BTN
// independent debounce channels.
module button_conditioner
    import tamagotchi_pkg::*;
#(
    parameter int N_BTN      = DEF_N_BTN,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int DEB_TICKS  = DEF_DEB_TICKS,
    parameter int LONG_TICKS = DEF_LONG_TICKS
) (
    input logic           clk,
    input logic           rst,
    button_conditioner_if.slave bus
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [N_BTN-1:0] level_w, press_w, long_w, rel_w;

    // Prescaler wraps at TICK_DIV-1; tick is high for that single cycle.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div_q <= '0;
        else      div_q <= div_d;
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        btn_channel #(
            .DEB_TICKS  (DEB_TICKS),
            .LONG_TICKS (LONG_TICKS)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .btn_n         (bus.btn_n[gi]),
            .level         (level_w[gi]),
            .press_pulse   (press_w[gi]),
            .long_pulse    (long_w[gi]),
            .release_pulse (rel_w[gi])
        );
    end

    assign bus.level         = level_w;
    assign bus.press_pulse   = press_w;
    assign bus.long_pulse    = long_w;
    assign bus.release_pulse = rel_w;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 5, meaning the number of button channels (Sleep, Awake, Feed, Play, Test).
REQ-002 SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per time tick (1 ms at 50 MHz).
REQ-003 SHALL have parameter DEB_TICKS, default 20, meaning the ticks of stable input required to accept a change.
REQ-004 SHALL have parameter LONG_TICKS, default 5000, meaning the ticks held after acceptance before a long-press event.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port btn_n, input, N_BTN bits: raw asynchronous push-buttons, active-low (0 = pressed).
REQ-008 SHALL have port level, output, N_BTN bits: debounced pressed state, active-high.
REQ-009 SHALL have port press_pulse, output, N_BTN bits: one-clk pulse on accepted press.
REQ-010 SHALL have port long_pulse, output, N_BTN bits: one-clk pulse on long-press threshold.
REQ-011 SHALL have port release_pulse, output, N_BTN bits: one-clk pulse on accepted release.

Function
REQ-012 SHALL pass each btn_n bit through a 2-flop synchronizer, then invert it to an active-high value s[i]; no logic SHALL sample btn_n directly.
REQ-013 SHALL contain one shared prescaler counting 0..TICK_DIV-1 that asserts tick for exactly one clk on wrap; tick SHALL be shared by all channels.
REQ-014 Each channel SHALL implement the FSM IDLE -> DEB_PRESS -> PRESSED -> LONG -> DEB_RELEASE -> IDLE, also PRESSED -> DEB_RELEASE.
REQ-015 IDLE: on s=1, go to DEB_PRESS with the debounce counter cleared.
REQ-016 DEB_PRESS: on s=0, return to IDLE with no pulse; on tick with s=1, increment the counter; when the counter reaches DEB_TICKS, go to PRESSED.
REQ-017 The IDLE/DEB_PRESS -> PRESSED transition SHALL assert press_pulse[i] for the one clk following the transition edge; level[i] SHALL rise on that same edge.
REQ-018 PRESSED: the hold counter SHALL be cleared on entry and SHALL increment on tick; when it reaches LONG_TICKS with s still 1, go to LONG and pulse long_pulse[i] once.
REQ-019 PRESSED/LONG: on s=0, go to DEB_RELEASE with the debounce counter cleared; in DEB_RELEASE, s=1 SHALL return to the originating state (PRESSED with its hold count preserved, or LONG) with no pulse.
REQ-020 DEB_RELEASE: when DEB_TICKS ticks elapse with s=0, go to IDLE, drop level[i], and pulse release_pulse[i] once.
REQ-021 long_pulse SHALL fire at most once per press; LONG SHALL hold indefinitely until release.
REQ-022 Counters SHALL saturate at their thresholds and never wrap; widths SHALL be $clog2 of threshold+1.
REQ-023 Channels SHALL be fully independent; simultaneous presses on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 At most one of press_pulse[i], long_pulse[i] and release_pulse[i] SHALL be high in any cycle.

Reset
REQ-025 rst=0 SHALL asynchronously force all channels to IDLE, clear the synchronizers (to released), the prescaler and all counters, and drive level, press_pulse, long_pulse and release_pulse to 0.
REQ-026 A button held through reset deassertion SHALL be treated as a new press and debounced from IDLE; reset mid-press SHALL emit no release_pulse.

Structure
REQ-027 The FSM state encoding (5 states, 3 bits) and default timing constants SHALL reside in a shared package, tamagotchi_pkg.
REQ-028 Per-channel logic SHALL be the sub-module btn_channel, instantiated N_BTN times by a generate loop; the prescaler SHALL stay in the top.

Verification (TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10)
REQ-029 Clean press on btn_n[0] held 100 clk -> one press_pulse[0] 12..18 clk after the falling edge, level[0]=1, no long_pulse.
REQ-030 Bounce: btn_n[2] toggles every 3 clk for 40 clk, then held low -> zero pulses during the bounce, exactly one press_pulse[2] after settling.
REQ-031 Hold btn_n[4] 300 clk -> press_pulse, then long_pulse[4] 40 clk (±4) later, exactly once; release -> release_pulse[4] 12..18 clk after the rising edge.
REQ-032 Simultaneous press on btn_n[1] and btn_n[3] -> press_pulse=5'b01010 in the same cycle.
REQ-033 Assert rst=0 while level[0]=1 -> all outputs 0 immediately, no release_pulse; with the button still held after rst=1 -> a new press_pulse after debounce.
REQ-034 Release glitch: btn_n[0] goes high 2 clk during PRESSED -> no release_pulse, level stays 1, and long_pulse timing is unchanged.
